// File: rtl/rf_wb_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter_pkg : writeback-arbiter constants and helpers          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package rf_wb_arbiter_pkg;
  import rv32_pkg::*;

  localparam int N_REQ_DEFAULT = 3;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_pkg.sv
// +--------------------------------------------------------------------+
// | rv32_pkg : core-wide types and sizes shared by RV32 pipeline blocks  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter_if : writeback requester valid/ready bundle            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface rf_wb_arbiter_if
  import rv32_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*REG_ADDR_W-1:0] req_rd;
  logic [N_REQ*XLEN-1:0]       req_data;
  logic [N_REQ-1:0]            req_ready;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready
  );

endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin picker, search from ptr_i     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0]  req_i,
  input  wire logic [IW-1:0] ptr_i,
  output logic      [N-1:0]  gnt_o,
  output logic      [IW-1:0] gnt_idx_o,
  output logic               gnt_valid_o
);

  always_comb begin : p_pick
    logic found;
    int   idx;
    found       = 1'b0;
    idx         = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = IW'(idx);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter : round-robin share of the reg_file write port plus    |
// |                 pending-write scoreboard for RAW stalls. Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_wb_arbiter
  import rv32_pkg::*;
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int XLEN  = 32,
  parameter int NREG  = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  rf_wb_arbiter_if.slave             wb_if,
  input  wire logic                  alloc_valid_i,
  input  wire logic [REG_ADDR_W-1:0] alloc_rd_i,
  input  wire logic                  flush_i,
  output logic                       reg_write_o,
  output logic      [REG_ADDR_W-1:0] rd_addr_o,
  output logic      [XLEN-1:0]       rd_data_o,
  output logic      [NREG-1:0]       busy_vec_o,
  output logic      [31:0]           wb_count_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      w_req;
  logic [N_REQ-1:0]      w_gnt;
  logic [IW-1:0]         w_gnt_idx;
  logic                  w_gnt_valid;
  logic [REG_ADDR_W-1:0] w_gnt_rd;
  logic [XLEN-1:0]       w_gnt_data;

  logic [IW-1:0]         rr_ptr_q,    rr_ptr_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [XLEN-1:0]       rd_data_q,   rd_data_d;
  logic [NREG-1:0]       busy_q,      busy_d;
  logic [31:0]           wb_count_q,  wb_count_d;

  // Masking requests with rst keeps req_ready low for the whole reset window.
  assign w_req = wb_if.req_valid & {N_REQ{~rst}};

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req_i       (w_req),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (w_gnt),
    .gnt_idx_o   (w_gnt_idx),
    .gnt_valid_o (w_gnt_valid)
  );

  assign wb_if.req_ready = w_gnt;
  assign w_gnt_rd   = wb_if.req_rd[int'(w_gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_gnt_data = wb_if.req_data[int'(w_gnt_idx)*XLEN +: XLEN];

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    wb_count_d  = wb_count_q;
    if (w_gnt_valid) begin
      rr_ptr_d  = IW'(rr_next(int'(w_gnt_idx), N_REQ));
      rd_addr_d = w_gnt_rd;
      rd_data_d = w_gnt_data;
      // x0 writes still take their round-robin slot but never retire.
      if (w_gnt_rd != '0) begin
        reg_write_d = 1'b1;
        wb_count_d  = wb_count_q + 32'd1;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (flush_i) begin
        busy_d[i] = 1'b0;
      end else if (alloc_valid_i && (alloc_rd_i == REG_ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (w_gnt_valid && (w_gnt_rd == REG_ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      busy_q      <= '0;
      wb_count_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign reg_write_o = reg_write_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign busy_vec_o  = busy_q;
  assign wb_count_o  = wb_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_rf_wb_arbiter : directed vector table plus reset corner cases     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        flush;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] busy_vec;
  logic [31:0] wb_count;

  rf_wb_arbiter_if #(.N_REQ(3), .XLEN(32)) bus ();

  rf_wb_arbiter #(.N_REQ(3), .XLEN(32), .NREG(32)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .wb_if         (bus),
    .alloc_valid_i (alloc_valid),
    .alloc_rd_i    (alloc_rd),
    .flush_i       (flush),
    .reg_write_o   (reg_write),
    .rd_addr_o     (rd_addr),
    .rd_data_o     (rd_data),
    .busy_vec_o    (busy_vec),
    .wb_count_o    (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple reg_file stand-in fed by the write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (reg_write && rd_addr != 5'd0) begin
      rf[rd_addr] <= rd_data;
    end
  end

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic        av;
    logic [4:0]  ard;
    logic        fl;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic av, input logic [4:0] ard,
                       input logic fl);
    bus.req_valid = v;
    bus.req_rd    = {r2, r1, r0};
    bus.req_data  = {d2, d1, d0};
    alloc_valid   = av;
    alloc_rd      = ard;
    flush         = fl;
  endtask

  initial begin
    // v, rd0..2, d0..2, alloc, ard, flush | rdy, we, addr, data, busy, cnt
    vec[0]  = '{3'b001, 5'd1, 5'd0, 5'd0, 32'hAAAABBBB, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0,
                3'b001, 1'b1, 5'd1, 32'hAAAABBBB, 32'h0, 32'd1};
    vec[1]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0,
                3'b000, 1'b0, 5'd1, 32'hAAAABBBB, 32'h0, 32'd1};
    vec[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 1'b0,
                3'b010, 1'b1, 5'd2, 32'h22222222, 32'h0, 32'd2};
    vec[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 1'b0,
                3'b100, 1'b1, 5'd3, 32'h33333333, 32'h0, 32'd3};
    vec[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 1'b0,
                3'b001, 1'b1, 5'd1, 32'h11111111, 32'h0, 32'd4};
    vec[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 1'b0,
                3'b010, 1'b1, 5'd2, 32'h22222222, 32'h0, 32'd5};
    vec[6]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 1'b0,
                3'b100, 1'b1, 5'd3, 32'h33333333, 32'h0, 32'd6};
    vec[7]  = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 1'b0,
                3'b010, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 32'd6};
    vec[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0,
                3'b000, 1'b0, 5'd0, 32'hDEADBEEF, 32'h20, 32'd6};
    vec[9]  = '{3'b100, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h55555555, 1'b1, 5'd5, 1'b0,
                3'b100, 1'b1, 5'd5, 32'h55555555, 32'h20, 32'd7};
    vec[10] = '{3'b001, 5'd5, 5'd0, 5'd0, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0,
                3'b001, 1'b1, 5'd5, 32'h5A5A5A5A, 32'h0, 32'd8};
    vec[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0,
                3'b000, 1'b0, 5'd5, 32'h5A5A5A5A, 32'h4, 32'd8};
    vec[12] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0,
                3'b000, 1'b0, 5'd5, 32'h5A5A5A5A, 32'h84, 32'd8};
    vec[13] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0,
                3'b000, 1'b0, 5'd5, 32'h5A5A5A5A, 32'h284, 32'd8};
    vec[14] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1,
                3'b000, 1'b0, 5'd5, 32'h5A5A5A5A, 32'h0, 32'd8};
    vec[15] = '{3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77777777, 1'b0, 5'd0, 1'b0,
                3'b100, 1'b1, 5'd7, 32'h77777777, 32'h0, 32'd9};
    vec[16] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0,
                3'b000, 1'b0, 5'd7, 32'h77777777, 32'h0, 32'd9};
    vec[17] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0,
                3'b000, 1'b0, 5'd7, 32'h77777777, 32'h8, 32'd9};
    vec[18] = '{3'b011, 5'd3, 5'd4, 5'd0, 32'h33330000, 32'h44440000, 32'h0, 1'b1, 5'd6, 1'b0,
                3'b001, 1'b1, 5'd3, 32'h33330000, 32'h40, 32'd10};
    vec[19] = '{3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'h44440000, 32'h0, 1'b0, 5'd0, 1'b0,
                3'b010, 1'b1, 5'd4, 32'h44440000, 32'h40, 32'd11};

    // Reset held with every requester asking: nothing may be granted.
    rst = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    32'(bus.req_ready), 32'h0);
    check("rst_we",       32'(reg_write),     32'h0);
    check("rst_busy",     busy_vec,           32'h0);
    check("rst_cnt",      wb_count,           32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].v, vec[i].rd0, vec[i].rd1, vec[i].rd2, vec[i].d0, vec[i].d1, vec[i].d2,
            vec[i].av, vec[i].ard, vec[i].fl);
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vec[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we",   i), 32'(reg_write), 32'(vec[i].we));
      check($sformatf("v%0d_addr", i), 32'(rd_addr),   32'(vec[i].addr));
      check($sformatf("v%0d_data", i), rd_data,        vec[i].data);
      check($sformatf("v%0d_busy", i), busy_vec,       vec[i].busy);
      check($sformatf("v%0d_cnt",  i), wb_count,       vec[i].cnt);
      if (i == 1) check("rf_x1_read", rf[1], 32'hAAAABBBB);
    end

    // Asynchronous reset mid-cycle kills the pending grant and the registered write.
    @(negedge clk);
    drive(3'b001, 5'd9, 5'd0, 5'd0, 32'h99999999, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    check("mid_ready_pre", 32'(bus.req_ready), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_ready", 32'(bus.req_ready), 32'h0);
    check("mid_we",    32'(reg_write),     32'h0);
    check("mid_addr",  32'(rd_addr),       32'h0);
    check("mid_data",  rd_data,            32'h0);
    check("mid_busy",  busy_vec,           32'h0);
    check("mid_cnt",   wb_count,           32'h0);
    @(posedge clk);
    #1;
    check("mid_we_edge", 32'(reg_write), 32'h0);

    // Pointer restarts at requester 0 after reset.
    @(negedge clk);
    rst = 1'b0;
    drive(3'b111, 5'd9, 5'd10, 5'd11, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b0, 5'd0, 1'b0);
    #1;
    check("post_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post_we",   32'(reg_write), 32'h1);
    check("post_addr", 32'(rd_addr),   32'd9);
    check("post_cnt",  wb_count,       32'd1);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
